imem_arbiter: RTL and testbench

Arbiter and boot sequencer for a single-ported, synchronous-read instruction RAM. It shares the RAM between the IF stage (read) and a program loader (write). After reset it holds the core until the loader finishes the boot image. During run it gives the loader priority, with a starvation guard so fetch still makes progress.

---
 rtl/imem_arbiter.sv | 136 +++++++++++++
 tb/tb_imem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares a single-ported, synchronous-read instruction RAM between the
// IF stage (reads) and a program loader (writes). Holds the core in BOOT until the
// loader signals the boot image is complete, then arbitrates with loader priority
// and a starvation guard that guarantees fetch progress.
module imem_arbiter #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned MAX_LOAD_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              fetch_req_i,
    input  logic [31:0]       fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_valid_o,
    output logic [31:0]       fetch_rdata_o,
    output logic              fetch_err_o,
    output logic              core_hold_o,

    input  logic              load_req_i,
    input  logic [31:0]       load_addr_i,
    input  logic [31:0]       load_wdata_i,
    output logic              load_gnt_o,
    input  logic              boot_done_i,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    localparam logic [3:0] MaxBurst = 4'(MAX_LOAD_BURST);

    state_e      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic        fetch_err_q, fetch_err_d;

    logic        fetch_aligned;
    logic        fetch_gnt, load_gnt;
    logic [ADDR_W-1:0] fetch_word, load_word;

    // Upper address bits are deliberately dropped: addresses wrap modulo the RAM size.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr_i[31:ADDR_W+2], load_addr_i[31:ADDR_W+2],
                                load_addr_i[1:0]};

    assign fetch_aligned = (fetch_addr_i[1:0] == 2'b00);
    assign fetch_word    = fetch_addr_i[ADDR_W+1:2];
    assign load_word     = load_addr_i[ADDR_W+1:2];

    // State and pipeline registers; reset wins over everything, including boot_done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StBoot;
            starve_cnt_q  <= 4'd0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Next-state: leave BOOT once the loader reports the image complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StBoot:  if (boot_done_i) state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    // Grant decode; nothing is granted while reset is asserted.
    always_comb begin
        fetch_gnt   = 1'b0;
        load_gnt    = 1'b0;
        core_hold_o = 1'b1;
        case (state_q)
            StBoot: begin
                core_hold_o = 1'b1;
                load_gnt    = load_req_i;
            end
            StRun: begin
                core_hold_o = 1'b0;
                if (load_req_i && fetch_req_i) begin
                    // Loader has priority until fetch has waited MAX_LOAD_BURST grants.
                    if (starve_cnt_q == MaxBurst) fetch_gnt = 1'b1;
                    else                          load_gnt  = 1'b1;
                end else begin
                    load_gnt  = load_req_i;
                    fetch_gnt = fetch_req_i;
                end
            end
            default: ;
        endcase
        if (rst_i) begin
            fetch_gnt = 1'b0;
            load_gnt  = 1'b0;
        end
    end

    // Starvation counter and fetch response pipeline next-state.
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        if (state_q != StRun || !fetch_req_i || fetch_gnt) begin
            // Arbitration only matters in RUN; a served or absent fetch resets the guard.
            starve_cnt_d = 4'd0;
        end else if (load_gnt && starve_cnt_q != MaxBurst) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
        fetch_valid_d = fetch_gnt & fetch_aligned;
        fetch_err_d   = fetch_gnt & ~fetch_aligned;
    end

    // RAM port drive; a misaligned fetch is consumed without touching the RAM.
    always_comb begin
        mem_en_o    = load_gnt | (fetch_gnt & fetch_aligned);
        mem_we_o    = load_gnt;
        mem_addr_o  = load_gnt ? load_word : fetch_word;
        mem_wdata_o = load_wdata_i;
    end

    assign fetch_gnt_o   = fetch_gnt;
    assign load_gnt_o    = load_gnt;
    assign fetch_valid_o = fetch_valid_q;
    assign fetch_err_o   = fetch_err_q;
    assign fetch_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed boot/starvation/misalign/wrap/RAW/reset steps
// followed by randomized traffic, all checked against a cycle-level reference model.
module tb_imem_arbiter;

    localparam int unsigned AW    = 5;
    localparam int unsigned MAXB  = 4;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_req, load_req, boot_done;
    logic [31:0]   fetch_addr, load_addr, load_wdata;
    logic          fetch_gnt, fetch_valid, fetch_err, core_hold, load_gnt;
    logic [31:0]   fetch_rdata, mem_wdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(AW), .MAX_LOAD_BURST(MAXB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fetch_req_i  (fetch_req),
        .fetch_addr_i (fetch_addr),
        .fetch_gnt_o  (fetch_gnt),
        .fetch_valid_o(fetch_valid),
        .fetch_rdata_o(fetch_rdata),
        .fetch_err_o  (fetch_err),
        .core_hold_o  (core_hold),
        .load_req_i   (load_req),
        .load_addr_i  (load_addr),
        .load_wdata_i (load_wdata),
        .load_gnt_o   (load_gnt),
        .boot_done_i  (boot_done),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    // Synchronous-read RAM attached to the arbiter.
    logic [31:0] ram [WORDS];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_run;
    int          m_starve;
    logic [31:0] m_mem   [WORDS];
    bit          m_known [WORDS];
    bit          p_valid, p_err, p_known;
    logic [31:0] p_data;
    logic        obs_fgnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit fr, input logic [31:0] fa, input bit lr,
                        input logic [31:0] la, input logic [31:0] lw, input bit bd);
        bit e_fg, e_lg, e_en, alig;
        int fidx, lidx;
        rst = r; fetch_req = fr; fetch_addr = fa; load_req = lr; load_addr = la;
        load_wdata = lw; boot_done = bd;
        alig = (fa % 4) == 0;
        fidx = int'((fa / 4) % WORDS);
        lidx = int'((la / 4) % WORDS);
        e_fg = 0; e_lg = 0;
        if (!r) begin
            if (!m_run)           e_lg = lr;
            else if (lr && fr) begin
                if (m_starve == MAXB) e_fg = 1;
                else                  e_lg = 1;
            end else begin
                e_lg = lr; e_fg = fr;
            end
        end
        e_en = e_lg || (e_fg && alig);
        #3;
        obs_fgnt = fetch_gnt;
        chk("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
        chk("load_gnt", 32'(load_gnt), 32'(e_lg));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("mem_we", 32'(mem_we), 32'(e_lg));
        chk("core_hold", 32'(core_hold), 32'(!m_run));
        chk("fetch_valid", 32'(fetch_valid), 32'(p_valid));
        chk("fetch_err", 32'(fetch_err), 32'(p_err));
        if (p_valid && p_known) chk("fetch_rdata", fetch_rdata, p_data);
        if (e_en) chk("mem_addr", 32'(mem_addr), e_lg ? lidx : fidx);
        if (e_lg) chk("mem_wdata", mem_wdata, lw);
        // Advance the model.
        p_valid = e_fg && alig;
        p_err   = e_fg && !alig;
        p_known = m_known[fidx];
        p_data  = m_mem[fidx];
        if (e_lg) begin
            m_mem[lidx]   = lw;
            m_known[lidx] = 1;
        end
        if (r || !m_run || e_fg || !fr) m_starve = 0;
        else if (e_lg && m_starve < MAXB) m_starve++;
        if (r)               m_run = 0;
        else if (!m_run && bd) m_run = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [9:0] pat;
        rst = 1; fetch_req = 0; load_req = 0; boot_done = 0;
        fetch_addr = 0; load_addr = 0; load_wdata = 0;
        for (int i = 0; i < WORDS; i++) m_known[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        m_run = 0; m_starve = 0; p_valid = 0; p_err = 0; p_known = 0; p_data = 0;
        obs_fgnt = 0;

        // Boot: load, fetch held off, boot_done, then fetch returns loaded word.
        step(1, 0, 0, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, 1, 32'h4, 32'h0050_0313, 0);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        step(0, 1, 32'h4, 0, 0, 0, 1);
        step(0, 1, 32'h4, 0, 0, 0, 0);
        chk("boot_rdata", fetch_rdata, 32'h0050_0313);
        idle();

        // Starvation guard with both requests held.
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h8, 1, 32'h40 + 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
            pat[9 - i] = obs_fgnt;
        end
        chk("starve_pattern", 32'(pat), 32'(10'b0000100001));
        idle();

        // Misaligned fetch.
        step(0, 1, 32'h6, 0, 0, 0, 0);
        chk("misalign_err", 32'(fetch_err), 32'd1);
        idle();

        // Wrap: byte 0x80 aliases word 0.
        step(0, 0, 0, 1, 32'h80, 32'hDEAD_BEEF, 0);
        step(0, 1, 32'h0, 0, 0, 0, 0);
        chk("wrap_rdata", fetch_rdata, 32'hDEAD_BEEF);

        // Read-after-write in consecutive cycles.
        step(0, 0, 0, 1, 32'h10, 32'h1234_5678, 0);
        step(0, 1, 32'h10, 0, 0, 0, 0);
        chk("raw_rdata", fetch_rdata, 32'h1234_5678);

        // Reset during a fetch request: response suppressed, back in BOOT, load granted.
        step(0, 1, 32'h10, 0, 0, 0, 0);
        step(1, 1, 32'h10, 1, 32'h20, 32'h5555_AAAA, 0);
        step(0, 0, 0, 1, 32'h20, 32'h5555_AAAA, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, fr, lr, bd;
            logic [31:0] fa, la;
            r  = ($urandom_range(0, 59) == 0);
            lr = ($urandom_range(0, 2) != 0);
            fr = ($urandom_range(0, 2) != 0);
            if (!m_run && lr) fr = 0;
            bd = ($urandom_range(0, 7) == 0);
            fa = {$urandom_range(0, 3) == 0 ? 25'($urandom) : 25'd0, 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 7) != 0) fa[1:0] = 2'b00;
            la = $urandom;
            step(r, fr, fa, lr, la, $urandom, bd);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
